// File: rtl/pc_sequencer_pkg.sv
// Shared instruction definitions for the program-counter sequencer:
// opcode encodings, instruction field positions and FSM state type.
package pc_sequencer_pkg;

    localparam int INSTR_W = 28;
    localparam int OPC_MSB = 27;
    localparam int OPC_LSB = 24;
    localparam int DST_MSB = 23;
    localparam int DST_LSB = 16;
    localparam int DST_W   = DST_MSB - DST_LSB + 1;

    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_STO  = 4'd1,
        OP_JMP  = 4'd2,
        OP_CALL = 4'd3,
        OP_RET  = 4'd4
    } opcode_t;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FAULT = 1'b1
    } seq_state_t;

endpackage

// File: rtl/return_stack.sv
// LIFO of return addresses; the caller must not push when full or pop
// when empty, but both are guarded here as well.
module return_stack #(
    parameter int AW    = 16,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [AW-1:0] din,
    output logic [AW-1:0] top,
    output logic [2:0]    depth,
    output logic          full,
    output logic          empty
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW-1:0] mem [DEPTH];
    logic [IW-1:0] wr_idx;
    logic [IW-1:0] rd_idx;

    assign wr_idx = IW'(depth);
    assign rd_idx = IW'(depth - 3'd1);
    assign top    = mem[rd_idx];
    assign full   = (depth == 3'(DEPTH));
    assign empty  = (depth == 3'd0);

    // Storage is intentionally left unreset; only the depth counter matters.
    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wr_idx] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst)
            depth <= 3'd0;
        else if (push && !full)
            depth <= depth + 3'd1;
        else if (pop && !empty)
            depth <= depth - 3'd1;
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter with zero-bubble JMP/CALL/RET/branch handling and a
// sticky FAULT state on return-stack overflow or underflow.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int ADDR_WIDTH  = 16,
    parameter int STACK_DEPTH = 4
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [INSTR_W-1:0]    iInstruction,
    input  logic                  iStall,
    input  logic                  iBranchTaken,
    input  logic [ADDR_WIDTH-1:0] iBranchTarget,
    output logic [ADDR_WIDTH-1:0] oAddress,
    output logic [2:0]            oReturnDepth,
    output logic                  oFault
);

    seq_state_t            state, next_state;
    logic [ADDR_WIDTH-1:0] pc, next_pc, pc_inc, dest, stack_top;
    logic [3:0]            opcode;
    logic                  push, pop, stack_full, stack_empty;
    logic                  unused_bits;

    assign opcode      = iInstruction[OPC_MSB:OPC_LSB];
    assign dest        = {{(ADDR_WIDTH-DST_W){1'b0}}, iInstruction[DST_MSB:DST_LSB]};
    assign pc_inc      = pc + 1'b1;
    assign unused_bits = ^iInstruction[DST_LSB-1:0];

    assign oAddress = pc;
    assign oFault   = (state == ST_FAULT);

    return_stack #(
        .AW    (ADDR_WIDTH),
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk   (Clock),
        .rst   (Reset),
        .push  (push),
        .pop   (pop),
        .din   (pc_inc),
        .top   (stack_top),
        .depth (oReturnDepth),
        .full  (stack_full),
        .empty (stack_empty)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            pc    <= '0;
            state <= ST_RUN;
        end else begin
            pc    <= next_pc;
            state <= next_state;
        end
    end

    // Control opcodes outrank the datapath branch; stall outranks everything.
    always_comb begin
        next_pc    = pc;
        next_state = state;
        push       = 1'b0;
        pop        = 1'b0;
        if (state == ST_RUN && !iStall) begin
            case (opcode)
                OP_JMP: next_pc = dest;
                OP_CALL: begin
                    if (stack_full) begin
                        next_state = ST_FAULT;
                    end else begin
                        push    = 1'b1;
                        next_pc = dest;
                    end
                end
                OP_RET: begin
                    if (stack_empty) begin
                        next_state = ST_FAULT;
                    end else begin
                        pop     = 1'b1;
                        next_pc = stack_top;
                    end
                end
                default: next_pc = iBranchTaken ? iBranchTarget : pc_inc;
            endcase
        end
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter ADDR_WIDTH, default 16: width of the instruction address and of each return-stack entry.
REQ-002 Parameter STACK_DEPTH, default 4: number of return-address entries.
REQ-003 Clock  input  1  the single clock; all state updates on its rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 iInstruction  input  28  current instruction word from the program ROM: opcode [27:24], destination [23:16].
REQ-006 iStall  input  1  when 1, the datapath holds the current instruction.
REQ-007 iBranchTaken  input  1  datapath-resolved conditional branch for the current instruction.
REQ-008 iBranchTarget  input  ADDR_WIDTH  target address used when iBranchTaken is applied.
REQ-009 oAddress  output  ADDR_WIDTH  program counter, driven directly from the PC register to the ROM address input.
REQ-010 oReturnDepth  output  3  number of valid return-stack entries.
REQ-011 oFault  output  1  sticky stack-error indicator.

Function
REQ-012 The PC register is the only source of oAddress; the ROM returns iInstruction combinationally in the same cycle, so control transfers SHALL take effect at the next edge with zero bubble cycles.
REQ-013 The FSM SHALL have two states, RUN and FAULT.
REQ-014 In RUN, the next PC SHALL be chosen in this priority order: iStall=1 -> hold PC, stack and depth; opcode JMP -> zero-extended destination; opcode CALL -> zero-extended destination, with PC+1 pushed; opcode RET -> popped top of stack; iBranchTaken=1 -> iBranchTarget; otherwise -> PC+1.
REQ-015 iBranchTaken SHALL be ignored whenever the opcode is JMP, CALL or RET.
REQ-016 PC+1 SHALL wrap modulo 2^ADDR_WIDTH (16'hFFFF -> 16'h0000), and a pushed return address SHALL wrap the same way.
REQ-017 CALL when oReturnDepth == STACK_DEPTH (overflow) SHALL leave the stack and PC unchanged, set oFault, and enter FAULT.
REQ-018 RET when oReturnDepth == 0 (underflow) SHALL leave the stack and PC unchanged, set oFault, and enter FAULT.
REQ-019 A push or pop SHALL change oReturnDepth by exactly 1 in the same edge as the PC update.
REQ-020 In FAULT, the PC, stack and depth SHALL hold and oFault SHALL stay 1 regardless of inputs; only Reset exits FAULT.
REQ-021 Stack contents above oReturnDepth are don't-care and SHALL NOT be observable.

Reset
REQ-022 Reset=1 at an edge SHALL force: PC=0, oAddress=0, oReturnDepth=0, oFault=0, state=RUN.
REQ-023 Reset SHALL have priority over every other input, including iStall and the FAULT state.
REQ-024 Reset asserted mid-subroutine SHALL discard all stacked return addresses.
REQ-025 Stack storage need not be reset.

Structure
REQ-026 Opcode encodings for NOP, STO, JMP, CALL and RET SHALL be defined only in the shared definitions header, and this block SHALL include that header.
REQ-027 The field-position constants (opcode [27:24], destination [23:16]) SHALL live in the same shared header.
REQ-028 The return stack SHALL be a sub-module named return_stack, with push, pop, data-in, top, depth, full and empty ports.
REQ-029 All next-PC selection and FSM logic SHALL live in pc_sequencer.

Verification
REQ-030 Release Reset and drive NOP at every address -> oAddress is 0,1,2,3 on consecutive cycles, with oReturnDepth=0.
REQ-031 CALL with destination 8 at address 3, then RET at address 9 -> oAddress sequence 3,8,9,4; oReturnDepth goes 0,1,1,0.
REQ-032 JMP with destination 5 at address 5 -> oAddress stays 5 indefinitely; with iStall=1 at address 2 for 3 cycles, oAddress holds at 2 for those 3 cycles and then goes to 3.
REQ-033 Nest 4 CALLs, then issue a 5th CALL -> oFault=1, oReturnDepth stays 4, and oAddress freezes at the 5th CALL address.
REQ-034 Issue RET with an empty stack -> oFault=1 and oAddress frozen; then assert Reset -> oAddress=0, oFault=0, oReturnDepth=0.
REQ-035 At address 16'hFFFF with a NOP -> next oAddress=0; a non-control opcode with iBranchTaken=1 and iBranchTarget=16'h0020 -> next oAddress=0x20; JMP with destination 7 and iBranchTaken=1 -> next oAddress=7.
